alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage_pkg.sv | 27 ++
 rtl/alu_exec_stage_if.sv | 34 +++
 rtl/alu_exec_stage_or32.sv | 13 +
 rtl/alu_exec_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
// ALU execute stage: shared opcode and flag definitions.
// Imported by the interface, the OR sub-module and the stage top.
package alu_exec_stage_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOR  = 3'b011,
      OP_ADD  = 3'b100,
      OP_SUB  = 3'b101,
      OP_SLT  = 3'b110,
      OP_SLTU = 3'b111
   } op_e;

   typedef struct packed {
      logic zf;
      logic nf;
      logic cf;
      logic vf;
   } flags_t;

   localparam flags_t FLAGS_CLR = '{zf: 1'b0, nf: 1'b0, cf: 1'b0, vf: 1'b0};

endpackage

// File: rtl/alu_exec_stage_if.sv
// ALU execute stage: issue/result handshake bundle.
// master = upstream/downstream side, slave = the stage.
interface alu_exec_stage_if
   import alu_exec_stage_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zf;
   logic             nf;
   logic             cf;
   logic             vf;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, y, zf, nf, cf, vf, op_count
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, y, zf, nf, cf, vf, op_count
   );

endinterface

// File: rtl/alu_exec_stage_or32.sv
// ALU execute stage: 32-bit OR datapath block.
// Purely combinational; used for the OR opcode path.
module or32
   import alu_exec_stage_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);

   assign y_o = a_i | b_i;

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one-entry result register with valid/ready.
// Computes logic/arith/compare ops and flags, counts accepts.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   alu_exec_stage_if.slave  bus
);

   localparam int MSB = WIDTH - 1;

   op_e              op;
   logic             accept;
   logic             sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             slt;
   logic             sltu;
   logic [WIDTH-1:0] or_y;
   logic [WIDTH-1:0] res;
   flags_t           res_f;

   logic [WIDTH-1:0] y_d,   y_q;
   flags_t           flg_d, flg_q;
   logic             vld_d, vld_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign op     = op_e'(bus.op);
   assign accept = bus.in_valid && bus.in_ready;

   // A slot frees up when empty or when the held result drains now.
   assign bus.in_ready = !vld_q || bus.out_ready;

   // Shared adder: SUB reuses it as a + ~b + 1.
   assign sub  = (op == OP_SUB);
   assign b_op = sub ? ~bus.b : bus.b;
   assign sum  = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
   assign ovf  = (bus.a[MSB] == b_op[MSB]) && (sum[MSB] != bus.a[MSB]);
   assign slt  = $signed(bus.a) < $signed(bus.b);
   assign sltu = bus.a < bus.b;

   generate
      if (WIDTH == 32) begin : g_or32
         or32 u_or (
            .a_i (bus.a),
            .b_i (bus.b),
            .y_o (or_y)
         );
      end else begin : g_or_inline
         assign or_y = bus.a | bus.b;
      end
   endgenerate

   // Result mux and flag generation for the op being issued.
   always_comb begin
      res      = '0;
      res_f    = FLAGS_CLR;
      case (op)
         OP_AND:  res = bus.a & bus.b;
         OP_OR:   res = or_y;
         OP_XOR:  res = bus.a ^ bus.b;
         OP_NOR:  res = ~(bus.a | bus.b);
         OP_ADD,
         OP_SUB: begin
            res      = sum[MSB:0];
            res_f.cf = sum[WIDTH];
            res_f.vf = ovf;
         end
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
         default: res = '0;
      endcase
      res_f.zf = (res == '0);
      res_f.nf = res[MSB];
   end

   // Next state: load on accept, drop valid on drain, saturate count.
   always_comb begin
      y_d   = y_q;
      flg_d = flg_q;
      vld_d = vld_q;
      cnt_d = cnt_q;
      if (accept) begin
         y_d   = res;
         flg_d = res_f;
         vld_d = 1'b1;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (bus.out_ready) begin
         vld_d = 1'b0;
      end
   end

   // Result register, valid bit and accept counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q   <= '0;
         flg_q <= FLAGS_CLR;
         vld_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         y_q   <= y_d;
         flg_q <= flg_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.y         = y_q;
   assign bus.zf        = flg_q.zf;
   assign bus.nf        = flg_q.nf;
   assign bus.cf        = flg_q.cf;
   assign bus.vf        = flg_q.vf;
   assign bus.op_count  = cnt_q;

endmodule
